// File: rtl/control_espirometro.sv
// Spirometer front-end sequencer: removes the baseline offset from raw flow samples and
// walks the test through IDLE/ESPERA/MEDICION/FIN, strobing each sample one cycle later.
module control_espirometro #(
  parameter logic [7:0] UMBRAL       = 8'd6,
  parameter int         N_ARRANQUE   = 3,
  parameter int         N_PARO       = 8,
  parameter int         MAX_MUESTRAS = 3000,
  parameter int         ANCHO_CNT    = 12
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iCE,
  input  logic [7:0] ivMuestra,
  input  logic       iInicio,
  output logic [7:0] ovDatos,
  output logic [1:0] ovStateMachine,
  output logic       oCE,
  output logic       oTimeout
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ESPERA   = 2'b01,
    MEDICION = 2'b10,
    FIN      = 2'b11
  } estado_t;

  localparam logic [ANCHO_CNT-1:0] CNT_MAX  = '1;
  localparam logic [ANCHO_CNT-1:0] UNO      = ANCHO_CNT'(1);
  localparam logic [ANCHO_CNT-1:0] ARRANQUE = ANCHO_CNT'(N_ARRANQUE);
  localparam logic [ANCHO_CNT-1:0] PARO     = ANCHO_CNT'(N_PARO);
  localparam logic [ANCHO_CNT-1:0] MAXM     = ANCHO_CNT'(MAX_MUESTRAS);

  estado_t              estado;
  logic [7:0]           offset;
  logic                 offset_pend;
  logic [ANCHO_CNT-1:0] racha, muestras;
  logic [ANCHO_CNT-1:0] racha_inc, muestras_inc;
  logic [8:0]           diff;
  logic [7:0]           corr;
  logic                 flujo;

  // 9-bit difference so a sample below the baseline clamps to 0 instead of wrapping.
  always_comb begin
    diff         = {1'b0, ivMuestra} - {1'b0, offset};
    corr         = diff[8] ? 8'd0 : diff[7:0];
    flujo        = corr > UMBRAL;
    racha_inc    = (racha == CNT_MAX) ? racha : racha + UNO;
    muestras_inc = (muestras == CNT_MAX) ? muestras : muestras + UNO;
  end

  assign ovStateMachine = estado;

  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      estado      <= IDLE;
      offset      <= 8'd0;
      offset_pend <= 1'b0;
      racha       <= '0;
      muestras    <= '0;
      ovDatos     <= 8'd0;
      oCE         <= 1'b0;
      oTimeout    <= 1'b0;
    end else begin
      oCE <= iCE;
      if (iCE) ovDatos <= 8'd0;
      case (estado)
        IDLE: begin
          if (iInicio) begin
            estado   <= ESPERA;
            racha    <= '0;
            muestras <= '0;
            if (iCE) begin
              offset      <= ivMuestra;
              offset_pend <= 1'b0;
            end else begin
              offset_pend <= 1'b1;
            end
          end
        end
        ESPERA: begin
          if (iCE) begin
            if (offset_pend) begin
              offset      <= ivMuestra;
              offset_pend <= 1'b0;
              racha       <= '0;
            end else begin
              ovDatos <= corr;
              if (!flujo) begin
                racha <= '0;
              end else if (racha_inc >= ARRANQUE) begin
                estado   <= MEDICION;
                racha    <= '0;
                muestras <= UNO;
              end else begin
                racha <= racha_inc;
              end
            end
          end
        end
        MEDICION: begin
          if (iCE) begin
            ovDatos  <= corr;
            muestras <= muestras_inc;
            racha    <= flujo ? '0 : racha_inc;
            // A quiet-run end takes priority over the timeout on the same sample.
            if (!flujo && racha_inc >= PARO) begin
              estado   <= FIN;
              oTimeout <= 1'b0;
              racha    <= '0;
              muestras <= '0;
            end else if (muestras_inc >= MAXM) begin
              estado   <= FIN;
              oTimeout <= 1'b1;
              racha    <= '0;
              muestras <= '0;
            end
          end
        end
        FIN: begin
          if (iInicio) begin
            estado   <= IDLE;
            oTimeout <= 1'b0;
            racha    <= '0;
            muestras <= '0;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_espirometro.sv
// Bench for control_espirometro: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a sample-history model of the test phases.
module tb_control_espirometro;

  localparam int UMBRAL       = 6;
  localparam int N_ARRANQUE   = 3;
  localparam int N_PARO       = 8;
  localparam int MAX_MUESTRAS = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [7:0] mu = 8'd0;
  logic       ini = 1'b0;
  logic [7:0] datos;
  logic [1:0] sm;
  logic       oce;
  logic       tout;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  control_espirometro dut (
    .iClk(clk), .iReset(rst_n), .iCE(ce), .ivMuestra(mu), .iInicio(ini),
    .ovDatos(datos), .ovStateMachine(sm), .oCE(oce), .oTimeout(tout)
  );

  always #5 clk = ~clk;

  // Model: phase number, baseline, and the corrected samples seen since entering the phase.
  int m_phase = 0;
  int m_off   = 0;
  bit m_first = 1'b0;
  int m_n     = 0;
  int hist[$];
  int e_datos = 0;
  int e_state = 0;
  bit e_ce    = 1'b0;
  bit e_to    = 1'b0;

  function automatic bit tail_all(int n, bit above);
    if (hist.size() < n) return 1'b0;
    for (int i = hist.size() - n; i < hist.size(); i++)
      if ((hist[i] > UMBRAL) != above) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int corr;
    if (!rst_n) begin
      m_phase = 0; m_off = 0; m_first = 0; m_n = 0; hist.delete();
      e_datos = 0; e_ce = 0; e_to = 0;
    end else begin
      corr = (int'(mu) >= m_off) ? int'(mu) - m_off : 0;
      e_ce = ce;
      if (ce) e_datos = 0;
      case (m_phase)
        0: if (ini) begin
          m_phase = 1; hist.delete();
          if (ce) m_off = int'(mu);
          m_first = !ce;
        end
        1: if (ce) begin
          if (m_first) begin
            m_off = int'(mu); m_first = 0;
          end else begin
            e_datos = corr;
            hist.push_back(corr);
            if (tail_all(N_ARRANQUE, 1'b1)) begin
              m_phase = 2; hist.delete(); m_n = 1;
            end
          end
        end
        2: if (ce) begin
          e_datos = corr;
          m_n++;
          hist.push_back(corr);
          if (tail_all(N_PARO, 1'b0)) begin
            m_phase = 3; e_to = 0; hist.delete();
          end else if (m_n >= MAX_MUESTRAS) begin
            m_phase = 3; e_to = 1; hist.delete();
          end
        end
        default: if (ini) begin
          m_phase = 0; e_to = 0;
        end
      endcase
    end
    e_state = m_phase;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_datos", int'(datos), e_datos);
      chk("model_state", int'(sm), e_state);
      chk("model_oce", int'(oce), int'(e_ce));
      chk("model_timeout", int'(tout), int'(e_to));
    end
  end

  task automatic step(input bit c, input int s, input bit i);
    ce = c; mu = 8'(s); ini = i;
    @(negedge clk);
  endtask

  initial begin
    int lvl;
    int sd_raw[5] = '{20, 20, 30, 30, 30};
    int sd_dat[5] = '{0, 0, 10, 10, 10};
    int sd_st[5]  = '{1, 1, 1, 1, 2};

    repeat (3) @(negedge clk);
    chk("reset_datos", int'(datos), 0);
    chk("reset_state", int'(sm), 0);
    chk("reset_oce", int'(oce), 0);
    chk("reset_timeout", int'(tout), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step(0, 0, 0);

    // Start, baseline 20, then three samples above threshold.
    step(0, 0, 1);
    chk("start_state", int'(sm), 1);
    chk("start_oce", int'(oce), 0);
    for (int k = 0; k < 5; k++) begin
      step(1, sd_raw[k], 0);
      chk("seq_oce", int'(oce), 1);
      chk("seq_datos", int'(datos), sd_dat[k]);
      chk("seq_state", int'(sm), sd_st[k]);
    end

    // Seven quiet samples broken by one flow sample, then eight quiet ones end the test.
    for (int k = 0; k < 7; k++) step(1, 24, 0);
    chk("quiet7_datos", int'(datos), 4);
    chk("quiet7_state", int'(sm), 2);
    step(1, 30, 0);
    chk("break_state", int'(sm), 2);
    for (int k = 0; k < 8; k++) begin
      step(1, 24, 0);
      chk("paro_state", int'(sm), (k == 7) ? 3 : 2);
    end
    chk("paro_timeout", int'(tout), 0);
    step(0, 0, 1);
    chk("fin_to_idle", int'(sm), 0);

    // iCE alone in IDLE, then start+iCE together with baseline 200, then a low sample.
    step(1, 99, 0);
    chk("idle_ce_oce", int'(oce), 1);
    chk("idle_ce_datos", int'(datos), 0);
    chk("idle_ce_state", int'(sm), 0);
    step(1, 200, 1);
    chk("start_ce_state", int'(sm), 1);
    chk("start_ce_datos", int'(datos), 0);
    step(1, 10, 0);
    chk("sat_datos", int'(datos), 0);
    chk("sat_state", int'(sm), 1);
    for (int k = 0; k < 3; k++) step(1, 250, 0);
    chk("med_datos", int'(datos), 50);
    chk("med_state", int'(sm), 2);
    step(1, 250, 1);
    chk("ini_in_med_ignored", int'(sm), 2);

    // Continuous flow until the sample limit; entry sample was 1, ignored-start sample was 2.
    for (int n = 3; n <= MAX_MUESTRAS; n++) begin
      step(1, 250, 0);
      if (n == MAX_MUESTRAS - 1) chk("pre_timeout_state", int'(sm), 2);
    end
    chk("timeout_state", int'(sm), 3);
    chk("timeout_flag", int'(tout), 1);
    step(0, 0, 1);
    chk("timeout_exit_state", int'(sm), 0);
    chk("timeout_exit_flag", int'(tout), 0);

    // Quiet-run end and sample limit land on the same sample: quiet end wins.
    step(1, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 100, 0);
    for (int k = 0; k < MAX_MUESTRAS - 9; k++) step(1, 100, 0);
    for (int k = 0; k < 8; k++) step(1, 3, 0);
    chk("both_state", int'(sm), 3);
    chk("both_timeout", int'(tout), 0);
    step(0, 0, 1);

    // Asynchronous reset in the middle of a measurement.
    step(1, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 100, 0);
    chk("pre_reset_state", int'(sm), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_datos", int'(datos), 0);
    chk("async_state", int'(sm), 0);
    chk("async_oce", int'(oce), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 100, 0);
    chk("post_reset_oce", int'(oce), 0);
    chk("post_reset_state", int'(sm), 0);

    // Random traffic: sample level drifts in blocks so runs of flow and quiet both occur.
    lvl = 0;
    for (int k = 0; k < 4000; k++) begin
      if (k % 16 == 0) lvl = $urandom_range(0, 255);
      step($urandom_range(0, 3) != 0, lvl ^ int'($urandom_range(0, 15)),
           $urandom_range(0, 24) == 0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
